// File: rtl/mem_responder.sv
// mem_responder
// -------------
// Byte-wide memory and IO responder for a simple CPU controller.
// Addresses whose bits [17:16] are 2'b11 fall in the IO region; every other
// address is RAM, indexed by the low ADDR_WIDTH bits. Within the IO region:
//   0x30000  write pushes a byte into the output FIFO toward the host sink
//   0x30004  write sets the sticky sim_halt flag
//   IO reads always return 8'h00.
//
// Ports
//   clk            single clock, all state updates on the rising edge
//   rst            asynchronous, active-low reset
//   rdy            global enable; when low, all state is frozen
//   mem_a          byte address from the controller
//   mem_wr         1 = write, 0 = read
//   mem_dout       write data from the controller
//   mem_din        registered read data to the controller (1-cycle latency)
//   io_buffer_full output FIFO near-full indication
//   io_tx_valid    FIFO head byte is valid
//   io_tx_data     FIFO head byte (0 when the FIFO is empty)
//   io_tx_ready    host sink accepts the head byte
//   sim_halt       sticky, set by a write to the halt port
//   io_overflow    sticky, set when a pushed byte was dropped
module mem_responder #(
  parameter int ADDR_WIDTH  = 17,
  parameter int FIFO_DEPTH  = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        io_tx_valid,
  output logic [7:0]  io_tx_data,
  input  logic        io_tx_ready,
  output logic        sim_halt,
  output logic        io_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(FIFO_DEPTH - FULL_MARGIN);

  logic [7:0]            ram [2**ADDR_WIDTH];
  logic [7:0]            fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  is_io;
  logic                  is_tx_port;
  logic                  is_halt_port;
  logic                  ram_we;
  logic                  push_req;
  logic                  push_ok;
  logic                  pop;
  logic                  unused_addr_bits;

  // Address decode. Only the exact port offsets are honoured, so the extra
  // bytes of a multi-byte store to 0x30000 land on ignored IO addresses.
  assign is_io        = (mem_a[17:16] == 2'b11);
  assign is_tx_port   = is_io && (mem_a[15:0] == 16'h0000);
  assign is_halt_port = is_io && (mem_a[15:0] == 16'h0004);
  assign ram_idx      = mem_a[ADDR_WIDTH-1:0];
  assign ram_we       = rdy && mem_wr && !is_io;
  assign unused_addr_bits = ^mem_a[31:18];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign io_tx_valid = (count != '0);
  assign pop         = rdy && io_tx_valid && io_tx_ready;
  assign push_req    = rdy && mem_wr && is_tx_port;
  assign push_ok     = push_req && ((count < DEPTH_C) || pop);
  assign io_tx_data  = io_tx_valid ? fifo_mem[rd_ptr] : 8'h00;

  always_comb begin
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // RAM array has no reset: its contents survive reset by design.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= mem_dout;
    end
  end

  // FIFO storage is not reset; io_tx_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= mem_dout;
    end
  end

  // Read data path, write-first for RAM writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_din <= 8'h00;
    end else if (rdy) begin
      if (is_io) begin
        mem_din <= 8'h00;
      end else if (mem_wr) begin
        mem_din <= mem_dout;
      end else begin
        mem_din <= ram[ram_idx];
      end
    end
  end

  // FIFO pointers, occupancy, near-full flag and sticky status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      io_buffer_full <= 1'b0;
      sim_halt       <= 1'b0;
      io_overflow    <= 1'b0;
    end else if (rdy) begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count          <= count_next;
      io_buffer_full <= (count_next >= THRESH_C);
      if (push_req && !push_ok) begin
        io_overflow <= 1'b1;
      end
      if (mem_wr && is_halt_port) begin
        sim_halt <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// ----------------
// Directed self-checking bench for mem_responder. Bytes accepted into the
// output FIFO are pushed onto a scoreboard queue; a negedge monitor pops and
// compares them as the host sink consumes them.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        io_tx_valid;
  logic [7:0]  io_tx_data;
  logic        io_tx_ready;
  logic        sim_halt;
  logic        io_overflow;

  int          tests;
  int          failed;
  logic [7:0]  sb[$];
  logic        exp_ovf;
  logic        exp_halt;

  mem_responder #(
    .ADDR_WIDTH (17),
    .FIFO_DEPTH (8),
    .FULL_MARGIN(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .mem_a         (mem_a),
    .mem_wr        (mem_wr),
    .mem_dout      (mem_dout),
    .mem_din       (mem_din),
    .io_buffer_full(io_buffer_full),
    .io_tx_valid   (io_tx_valid),
    .io_tx_data    (io_tx_data),
    .io_tx_ready   (io_tx_ready),
    .sim_halt      (sim_halt),
    .io_overflow   (io_overflow)
  );

  // Free-running 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports the failure.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one controller access for one clock. The scoreboard decides
  // whether a TX push is accepted from its own occupancy and the predicted
  // pop, and records the byte only after the edge so the monitor's pop of
  // the same edge is seen first.
  task automatic apply_stimulus(input logic [31:0] addr, input logic wr,
                                input logic [7:0] data);
    logic will_pop;
    logic is_tx;
    logic accept;
    mem_a    = addr;
    mem_wr   = wr;
    mem_dout = data;
    will_pop = rdy && io_tx_ready && (sb.size() != 0);
    is_tx    = rdy && wr && (addr == 32'h0003_0000);
    accept   = is_tx && ((sb.size() < 8) || will_pop);
    if (is_tx && !accept) exp_ovf = 1'b1;
    if (rdy && wr && (addr == 32'h0003_0004)) exp_halt = 1'b1;
    @(posedge clk);
    #1;
    if (accept) sb.push_back(data);
    mem_wr = 1'b0;
  endtask

  // Asynchronous reset pulse with immediate checks before any clock edge.
  task automatic reset_pulse();
    rst = 1'b0;
    #2;
    check_output("rst mem_din", mem_din, 8'h00);
    check_output("rst io_buffer_full", io_buffer_full, 1'b0);
    check_output("rst io_tx_valid", io_tx_valid, 1'b0);
    check_output("rst io_tx_data", io_tx_data, 8'h00);
    check_output("rst sim_halt", sim_halt, 1'b0);
    check_output("rst io_overflow", io_overflow, 1'b0);
    sb.delete();
    exp_ovf  = 1'b0;
    exp_halt = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Host-sink monitor: on each negedge, if a pop is due on the next edge,
  // the head byte must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (rst && rdy) begin
      if (io_tx_ready && (sb.size() != 0)) begin
        check_output("drain io_tx_valid", io_tx_valid, 1'b1);
        check_output("drain io_tx_data", io_tx_data, sb[0]);
        void'(sb.pop_front());
      end else if (sb.size() == 0) begin
        check_output("empty io_tx_valid", io_tx_valid, 1'b0);
      end
    end
  end

  // Directed test sequence.
  initial begin
    tests = 0;
    failed = 0;
    exp_ovf = 1'b0;
    exp_halt = 1'b0;
    rst = 1'b0;
    rdy = 1'b1;
    mem_a = 32'h0;
    mem_wr = 1'b0;
    mem_dout = 8'h00;
    io_tx_ready = 1'b0;

    // Reset state before any clock edge.
    #2;
    check_output("init mem_din", mem_din, 8'h00);
    check_output("init io_buffer_full", io_buffer_full, 1'b0);
    check_output("init io_tx_valid", io_tx_valid, 1'b0);
    check_output("init io_tx_data", io_tx_data, 8'h00);
    check_output("init sim_halt", sim_halt, 1'b0);
    check_output("init io_overflow", io_overflow, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // RAM preload, write-first and 1-cycle read latency.
    apply_stimulus(32'h0001_0004, 1'b1, 8'h77);
    apply_stimulus(32'h0000_0011, 1'b1, 8'h3C);
    check_output("ram write-first 3C", mem_din, 8'h3C);
    apply_stimulus(32'h0000_0010, 1'b1, 8'hA5);
    check_output("ram write-first A5", mem_din, 8'hA5);
    apply_stimulus(32'h0000_0010, 1'b0, 8'h00);
    check_output("ram read 10", mem_din, 8'hA5);
    apply_stimulus(32'h0000_0011, 1'b0, 8'h00);
    check_output("ram read 11", mem_din, 8'h3C);
    apply_stimulus(32'hFF00_0010, 1'b0, 8'h00);
    check_output("ram read upper bits ignored", mem_din, 8'hA5);

    // Fill with the sink stalled; 9th push overflows.
    io_tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(32'h0003_0000, 1'b1, 8'(8'h41 + i));
      check_output("fill io_buffer_full", io_buffer_full, (sb.size() >= 6));
      check_output("fill io_tx_data", io_tx_data, 8'h41);
      check_output("fill io_overflow", io_overflow, exp_ovf);
    end
    check_output("fill overflow set", io_overflow, 1'b1);

    // Drain in order while reading RAM.
    io_tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(32'h0000_0010, 1'b0, 8'h00);
      check_output("drain io_buffer_full", io_buffer_full, (sb.size() >= 6));
    end
    check_output("drained io_tx_valid", io_tx_valid, 1'b0);
    check_output("drain mem_din", mem_din, 8'hA5);
    check_output("overflow sticky", io_overflow, 1'b1);

    // Reset mid-life, then push into a full FIFO while it drains.
    reset_pulse();
    io_tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(32'h0003_0000, 1'b1, 8'(8'h61 + i));
    end
    check_output("full io_buffer_full", io_buffer_full, 1'b1);
    check_output("full first entry", io_tx_data, 8'h61);
    io_tx_ready = 1'b1;
    apply_stimulus(32'h0003_0000, 1'b1, 8'h5A);
    check_output("push+pop full io_buffer_full", io_buffer_full, 1'b1);
    check_output("push+pop full io_overflow", io_overflow, 1'b0);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(32'h0000_0011, 1'b0, 8'h00);
    end
    check_output("5A drained io_tx_valid", io_tx_valid, 1'b0);
    check_output("5A drained io_overflow", io_overflow, 1'b0);

    // Count-of-1 FIFO with simultaneous push and pop.
    io_tx_ready = 1'b0;
    apply_stimulus(32'h0003_0000, 1'b1, 8'h71);
    io_tx_ready = 1'b1;
    apply_stimulus(32'h0003_0000, 1'b1, 8'h72);
    check_output("count1 io_tx_valid", io_tx_valid, 1'b1);
    check_output("count1 io_tx_data", io_tx_data, 8'h72);
    apply_stimulus(32'h0000_0000, 1'b0, 8'h00);
    check_output("count1 drained", io_tx_valid, 1'b0);

    // Halt port, IO reads and ignored IO writes.
    apply_stimulus(32'h0003_0004, 1'b1, 8'h00);
    check_output("halt set", sim_halt, exp_halt);
    apply_stimulus(32'h0001_0004, 1'b0, 8'h00);
    check_output("halt ram untouched", mem_din, 8'h77);
    apply_stimulus(32'h0003_0000, 1'b0, 8'h00);
    check_output("io read 30000", mem_din, 8'h00);
    check_output("io read no push", io_tx_valid, 1'b0);
    apply_stimulus(32'h0001_0004, 1'b0, 8'h00);
    apply_stimulus(32'h0003_0004, 1'b0, 8'h00);
    check_output("io read 30004", mem_din, 8'h00);
    apply_stimulus(32'h0003_0001, 1'b1, 8'hBB);
    apply_stimulus(32'h0003_0008, 1'b1, 8'hCC);
    check_output("ignored io writes", io_tx_valid, 1'b0);
    check_output("halt sticky", sim_halt, 1'b1);

    // Freeze with rdy low, then reset while frozen.
    io_tx_ready = 1'b0;
    apply_stimulus(32'h0003_0000, 1'b1, 8'h81);
    apply_stimulus(32'h0003_0000, 1'b1, 8'h82);
    apply_stimulus(32'h0003_0000, 1'b1, 8'h83);
    apply_stimulus(32'h0000_0010, 1'b0, 8'h00);
    rdy = 1'b0;
    io_tx_ready = 1'b1;
    apply_stimulus(32'h0003_0000, 1'b1, 8'h99);
    apply_stimulus(32'h0000_0010, 1'b1, 8'hEE);
    check_output("frozen mem_din", mem_din, 8'hA5);
    check_output("frozen io_tx_valid", io_tx_valid, 1'b1);
    check_output("frozen io_tx_data", io_tx_data, 8'h81);
    check_output("frozen io_buffer_full", io_buffer_full, 1'b0);
    check_output("frozen sim_halt", sim_halt, 1'b1);
    reset_pulse();
    rdy = 1'b1;
    io_tx_ready = 1'b0;
    apply_stimulus(32'h0000_0010, 1'b0, 8'h00);
    check_output("ram survives reset", mem_din, 8'hA5);
    apply_stimulus(32'h0003_0000, 1'b1, 8'hD1);
    check_output("first push after reset", io_tx_data, 8'hD1);
    check_output("post reset overflow", io_overflow, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
